// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared state encoding and constants for the pipeline controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } pipe_state_e;

  localparam logic [31:0] NOP_IR   = 32'h0000_0000;
  localparam int          REG_ZERO = 0;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
// ============================================================================
// hazard_detect : combinational load-use comparator between F/D and D/X
// Revision      : 1.0
// ============================================================================
`default_nettype none

module hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] fd_rs1,
  input  logic [REG_BITS-1:0] fd_rs2,
  input  logic                fd_uses_rs2,
  input  logic                dx_is_load,
  input  logic [REG_BITS-1:0] dx_rd,
  output logic                load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = (dx_rd == fd_rs1);
    rs2_hit  = fd_uses_rs2 && (dx_rd == fd_rs2);
    // A load into the zero register never produces a value to wait for
    load_use = dx_is_load && (dx_rd != REG_BITS'(REG_ZERO)) && (rs1_hit || rs2_hit);
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : hazard/stall controller for the five-stage pipeline latches
//             Optional stall counter enabled by macro PIPE_PERF_CNT_EN
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_BITS = 5
) (
  input  logic                clock,
  input  logic                ctrl_reset_n,
  input  logic [REG_BITS-1:0] fd_rs1,
  input  logic [REG_BITS-1:0] fd_rs2,
  input  logic                fd_uses_rs2,
  input  logic                dx_is_load,
  input  logic [REG_BITS-1:0] dx_rd,
  input  logic                dx_md_op,
  input  logic                x_branch_taken,
  input  logic                md_ready,
  input  logic                md_exception,
  output logic                md_start,
  output logic                we_pc,
  output logic                we_fd,
  output logic                we_dx,
  output logic                we_xm,
  output logic                we_mw,
  output logic                flush_fd,
  output logic                flush_dx,
  output logic                flush_xm
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  pipe_state_e state_q;
  pipe_state_e state_d;
  logic        load_use;

  hazard_detect #(
    .REG_BITS (REG_BITS)
  ) u_hazard_detect (
    .fd_rs1      (fd_rs1),
    .fd_rs2      (fd_rs2),
    .fd_uses_rs2 (fd_uses_rs2),
    .dx_is_load  (dx_is_load),
    .dx_rd       (dx_rd),
    .load_use    (load_use)
  );

  always_comb begin
    state_d  = state_q;
    md_start = 1'b0;
    we_pc    = 1'b0;
    we_fd    = 1'b0;
    we_dx    = 1'b0;
    we_xm    = 1'b0;
    we_mw    = 1'b0;
    flush_fd = 1'b0;
    flush_dx = 1'b0;
    flush_xm = 1'b0;

    case (state_q)
      RUN: begin
        if (dx_md_op) begin
          md_start = 1'b1;
          we_xm    = 1'b1;
          flush_xm = 1'b1;
          we_mw    = 1'b1;
          state_d  = MD_WAIT;
        end else if (x_branch_taken) begin
          {we_pc, we_fd, we_dx, we_xm, we_mw} = 5'b11111;
          flush_fd = 1'b1;
          flush_dx = 1'b1;
        end else if (load_use) begin
          we_dx    = 1'b1;
          flush_dx = 1'b1;
          we_xm    = 1'b1;
          we_mw    = 1'b1;
        end else begin
          {we_pc, we_fd, we_dx, we_xm, we_mw} = 5'b11111;
        end
      end
      MD_WAIT: begin
        // Completion lets X/M capture the unit's result; hazards wait a cycle
        if (md_ready || md_exception) begin
          {we_pc, we_fd, we_dx, we_xm, we_mw} = 5'b11111;
          state_d = RUN;
        end else begin
          we_xm    = 1'b1;
          flush_xm = 1'b1;
          we_mw    = 1'b1;
        end
      end
    endcase

    if (!ctrl_reset_n) begin
      md_start = 1'b0;
      {we_pc, we_fd, we_dx, we_xm, we_mw} = 5'b00000;
      {flush_fd, flush_dx, flush_xm}      = 3'b000;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!we_pc && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed scoreboard bench for pipe_ctrl
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  // {md_start, we_pc, we_fd, we_dx, we_xm, we_mw, flush_fd, flush_dx, flush_xm}
  localparam logic [8:0] EXP_ZERO = 9'b0_00000_000;
  localparam logic [8:0] EXP_RUN  = 9'b0_11111_000;
  localparam logic [8:0] EXP_BR   = 9'b0_11111_110;
  localparam logic [8:0] EXP_LU   = 9'b0_00111_010;
  localparam logic [8:0] EXP_MDS  = 9'b1_00011_001;
  localparam logic [8:0] EXP_MDW  = 9'b0_00011_001;

  logic       clock;
  logic       ctrl_reset_n;
  logic [4:0] fd_rs1, fd_rs2, dx_rd;
  logic       fd_uses_rs2, dx_is_load, dx_md_op, x_branch_taken, md_ready, md_exception;
  logic       md_start, we_pc, we_fd, we_dx, we_xm, we_mw, flush_fd, flush_dx, flush_xm;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] sb_q[$];
  int exp_stall = 0;

  pipe_ctrl #(.REG_BITS(5)) dut (
    .clock          (clock),
    .ctrl_reset_n   (ctrl_reset_n),
    .fd_rs1         (fd_rs1),
    .fd_rs2         (fd_rs2),
    .fd_uses_rs2    (fd_uses_rs2),
    .dx_is_load     (dx_is_load),
    .dx_rd          (dx_rd),
    .dx_md_op       (dx_md_op),
    .x_branch_taken (x_branch_taken),
    .md_ready       (md_ready),
    .md_exception   (md_exception),
    .md_start       (md_start),
    .we_pc          (we_pc),
    .we_fd          (we_fd),
    .we_dx          (we_dx),
    .we_xm          (we_xm),
    .we_mw          (we_mw),
    .flush_fd       (flush_fd),
    .flush_dx       (flush_dx),
    .flush_xm       (flush_xm)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs();
    fd_rs1 = 5'd0; fd_rs2 = 5'd0; fd_uses_rs2 = 1'b0;
    dx_is_load = 1'b0; dx_rd = 5'd0; dx_md_op = 1'b0;
    x_branch_taken = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
  endtask

  // One cycle: inputs applied after the edge are already set by the caller
  // via idle_inputs/overrides; the expected vector is queued, then checked
  // at the falling edge.
  task automatic cycle(input string tag, input logic rst_n, input logic [8:0] exp_vec);
    logic [8:0] obs;
    logic [8:0] want;
    ctrl_reset_n = rst_n;
    sb_q.push_back(exp_vec);
    @(negedge clock);
    obs  = {md_start, we_pc, we_fd, we_dx, we_xm, we_mw, flush_fd, flush_dx, flush_xm};
    want = sb_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
`ifdef PIPE_PERF_CNT_EN
    if (!rst_n) exp_stall = 0;
    checks++;
    assert (stall_cycles === 32'(exp_stall)) else begin
      errors++;
      $error("FAIL %s_stall observed=%0d expected=%0d", tag, stall_cycles, exp_stall);
    end
`endif
    if (rst_n && !want[7]) exp_stall++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle_inputs();
    ctrl_reset_n = 1'b0;
    #1;
    // Reset gates everything even with active requests present
    dx_md_op = 1'b1; x_branch_taken = 1'b1;
    cycle("reset", 1'b0, EXP_ZERO);

    idle_inputs();
    cycle("release", 1'b1, EXP_RUN);

    dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs1 = 5'd5;
    cycle("lu_rs1", 1'b1, EXP_LU);
    idle_inputs();
    cycle("lu_cleared", 1'b1, EXP_RUN);

    dx_is_load = 1'b1; dx_rd = 5'd0; fd_rs1 = 5'd0;
    cycle("lu_rd_zero", 1'b1, EXP_RUN);

    idle_inputs();
    dx_is_load = 1'b1; dx_rd = 5'd7; fd_rs1 = 5'd3; fd_rs2 = 5'd7; fd_uses_rs2 = 1'b1;
    cycle("lu_rs2", 1'b1, EXP_LU);
    fd_uses_rs2 = 1'b0;
    cycle("lu_rs2_unused", 1'b1, EXP_RUN);

    idle_inputs();
    x_branch_taken = 1'b1;
    cycle("branch", 1'b1, EXP_BR);
    dx_is_load = 1'b1; dx_rd = 5'd9; fd_rs1 = 5'd9;
    cycle("branch_over_lu", 1'b1, EXP_BR);

    idle_inputs();
    md_ready = 1'b1;
    cycle("stray_ready", 1'b1, EXP_RUN);
    md_ready = 1'b0; md_exception = 1'b1;
    cycle("stray_exc", 1'b1, EXP_RUN);

    // Mult/div completing four cycles after start; hazards ignored while waiting
    idle_inputs();
    dx_md_op = 1'b1;
    cycle("md_start", 1'b1, EXP_MDS);
    x_branch_taken = 1'b1;
    cycle("md_wait1", 1'b1, EXP_MDW);
    x_branch_taken = 1'b0; dx_is_load = 1'b1; dx_rd = 5'd4; fd_rs1 = 5'd4;
    cycle("md_wait2", 1'b1, EXP_MDW);
    idle_inputs(); dx_md_op = 1'b1;
    cycle("md_wait3", 1'b1, EXP_MDW);
    md_ready = 1'b1;
    cycle("md_ready", 1'b1, EXP_RUN);

    // Back-to-back op, this one ending with an exception on the 2nd wait cycle
    md_ready = 1'b0;
    cycle("md2_start", 1'b1, EXP_MDS);
    cycle("md2_wait1", 1'b1, EXP_MDW);
    md_exception = 1'b1;
    cycle("md2_exc", 1'b1, EXP_RUN);
    idle_inputs();
    cycle("md2_after", 1'b1, EXP_RUN);

    // Reset while waiting aborts the op
    dx_md_op = 1'b1;
    cycle("md3_start", 1'b1, EXP_MDS);
    cycle("md3_wait1", 1'b1, EXP_MDW);
    cycle("md3_reset", 1'b0, EXP_ZERO);
    idle_inputs();
    cycle("md3_release", 1'b1, EXP_RUN);
    cycle("md3_idle", 1'b1, EXP_RUN);
    dx_md_op = 1'b1;
    cycle("md4_start", 1'b1, EXP_MDS);
    idle_inputs();
    md_ready = 1'b1;
    cycle("md4_ready", 1'b1, EXP_RUN);
    md_ready = 1'b0;
    cycle("final_run", 1'b1, EXP_RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and stall controller for the five-stage processor pipeline. It drives the write enables and bubble (flush-to-NOP) controls of the PC register and the four inter-stage latches (F/D, D/X, X/M, M/W). Each latch holds PC, A, B and IR. The block sequences three events: load-use stalls, taken-branch squashes, and the multicycle mult/div start/ready handshake. It sits beside the datapath and is purely a control source; latch storage stays in the datapath.

## Interface
Parameters:
- REG_BITS, 5, width of register specifiers.

Ports:
- clock  in  1  pipeline clock, rising edge.
- ctrl_reset_n  in  1  asynchronous, active-low reset.
- fd_rs1, fd_rs2  in  REG_BITS  source registers of the instruction in F/D.
- fd_uses_rs2  in  1  F/D instruction reads rs2.
- dx_is_load  in  1  D/X instruction is a load.
- dx_rd  in  REG_BITS  destination register of the D/X instruction.
- dx_md_op  in  1  D/X instruction is mult/div.
- x_branch_taken  in  1  branch resolved taken in X this cycle.
- md_ready  in  1  mult/div result valid (single-cycle pulse).
- md_exception  in  1  mult/div error (e.g. div by zero), pulse.
- md_start  out  1  one-cycle start pulse to the mult/div unit.
- we_pc, we_fd, we_dx, we_xm, we_mw  out  1  latch write enables.
- flush_fd, flush_dx, flush_xm  out  1  load NOP IR into that latch on this edge; always asserted together with the matching we.
- stall_cycles  out  32  stall counter; present only with PIPE_PERF_CNT_EN.

## Operation
- FSM states: RUN, MD_WAIT.
- All outputs are combinational from the current state and inputs. Only the state and the counter are registered.
- Evaluation in RUN is by priority, highest first.

RUN, rule 1 (dx_md_op=1):
- md_start=1.
- we_pc=we_fd=we_dx=0.
- we_xm=1, flush_xm=1; we_mw=1.
- Next state MD_WAIT.

RUN, rule 2 (x_branch_taken=1):
- All we=1.
- flush_fd=1, flush_dx=1. This gives two bubbles; the PC loads the target through the external mux.

RUN, rule 3 (load-use):
- Condition: dx_is_load AND dx_rd≠0 AND (dx_rd==fd_rs1 OR (fd_uses_rs2 AND dx_rd==fd_rs2)).
- we_pc=we_fd=0.
- we_dx=1 with flush_dx=1.
- we_xm=we_mw=1.

RUN, otherwise: all we=1, no flush.

MD_WAIT:
- md_start=0.
- Hold PC, F/D and D/X. X/M is loaded with NOP each cycle; M/W advances.
- md_ready=1 or md_exception=1:
  - All we=1, no flush, so X/M captures the result.
  - Next state RUN.
  - Hazard rules are not evaluated in this cycle.
- Branch and load-use inputs are ignored in MD_WAIT.
- md_ready or md_exception arriving in RUN is ignored.

## Timing
- Reset (ctrl_reset_n=0): state=RUN immediately. While reset is asserted, all we, all flush and md_start are 0. stall_cycles=0.
- md_start is asserted in exactly one cycle per mult/div op: the RUN cycle in which dx_md_op is seen.
- A single-cycle mult/div (md_ready on the first MD_WAIT cycle) costs exactly 1 stall cycle. An op completing N cycles after start costs N stall cycles.
- A load-use stall costs 1 cycle. After the bubble the hazard condition clears.
- A taken branch costs 2 bubbles and no hold.
- Back-to-back mult/div ops: after RUN resumes, the next op in D/X triggers a fresh md_start on the following cycle.
- Reset during MD_WAIT aborts immediately. The mult/div unit is reset by the same net.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with ctrl_reset_n=1 and we_pc=0.
  - It saturates at 32'hFFFF_FFFF.
- PIPE_PERF_CNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package pipe_pkg:
  - State encoding (RUN=1'b0, MD_WAIT=1'b1).
  - NOP_IR=32'h0000_0000.
  - REG_ZERO=0.
- Sub-module hazard_detect: purely combinational load-use comparator. It takes fd_rs1, fd_rs2, fd_uses_rs2, dx_is_load, dx_rd and outputs load_use.
- Top level: FSM, priority mux, optional counter.

## Test plan
- Load-use: dx_is_load=1, dx_rd=5, fd_rs1=5 in RUN → we_pc=we_fd=0, we_dx=flush_dx=1 for exactly 1 cycle. The same stimulus with dx_rd=0 → no stall.
- Branch: x_branch_taken=1 → all we=1, flush_fd=flush_dx=1 for 1 cycle. With a load-use condition also true, the branch still wins and there is no hold.
- Mult/div: dx_md_op=1, md_ready asserted 4 cycles after md_start → md_start high 1 cycle, PC/F/D/D/X held 4 cycles, X/M receives NOP in those cycles, then all we=1. stall_cycles=4 with PIPE_PERF_CNT_EN.
- Exception: md_exception pulse on the 2nd MD_WAIT cycle → return to RUN and all we=1 in that cycle.
- Reset mid-op: ctrl_reset_n low during MD_WAIT → all outputs 0 at once. After release: state RUN, md_start low until a new dx_md_op.
- Stray md_ready in RUN → no output change.
